fir_datapath: RTL and testbench

Execution datapath for the FIR filter. Each cycle it executes the micro-op issued by the filter controller (`op`/`src1`/`src2`/`dest`) against a 16-entry signed register file. It returns a same-cycle `overflow` flag, which the controller samples in its ADD/SUB states, and it presents the accumulator (register 0) as the filter output. It sits between the controller and the output/AHB wrapper, and it is the responder end of the controller's micro-op interface.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_regfile.sv | 44 ++++
 rtl/fir_datapath.sv | 108 ++++++++++
 tb/tb_fir_datapath.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR execution datapath.
package fir_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 17;
    localparam int unsigned FRAC_W   = 15;
    localparam int unsigned ACC_IDX  = 0;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned EXT_W    = 16;
    localparam int unsigned OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'b000,
        OP_COPY  = 3'b001,
        OP_LOAD1 = 3'b010,
        OP_LOAD2 = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_MUL   = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    typedef logic signed [REG_W-1:0] reg_t;

    // True for every op that commits a result to the register file.
    function automatic logic op_writes(input op_t o);
        return (o inside {OP_COPY, OP_LOAD1, OP_LOAD2, OP_ADD, OP_SUB, OP_MUL});
    endfunction

endpackage

// File: rtl/fir_regfile.sv
// Register file: two combinational read ports, one write port, async reset, sync clear.
module fir_regfile #(
    parameter int unsigned NUM_REGS = fir_pkg::NUM_REGS,
    parameter int unsigned REG_W    = fir_pkg::REG_W,
    parameter int unsigned ADDR_W   = fir_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [REG_W-1:0]  rdata1_c,
    output logic [REG_W-1:0]  rdata2_c,
    output logic [REG_W-1:0]  acc
);
    import fir_pkg::*;

    localparam logic [ADDR_W-1:0] ACC_ADDR = ADDR_W'(ACC_IDX);

    logic [REG_W-1:0] regs [NUM_REGS];

    // Clear wins over any write issued in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1_c = regs[raddr1];
    assign rdata2_c = regs[raddr2];
    assign acc      = regs[ACC_ADDR];

endmodule

// File: rtl/fir_datapath.sv
// FIR micro-op execution datapath: ALU, overflow detect and optional clamp over the register file.
// Build option: define FIR_DP_SAT_EN to clamp overflowing ADD/SUB/MUL results instead of wrapping.
module fir_datapath #(
    parameter int unsigned NUM_REGS = fir_pkg::NUM_REGS,
    parameter int unsigned REG_W    = fir_pkg::REG_W,
    parameter int unsigned FRAC_W   = fir_pkg::FRAC_W
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       clear,
    input  logic [fir_pkg::OP_W-1:0]   op,
    input  logic [fir_pkg::ADDR_W-1:0] src1,
    input  logic [fir_pkg::ADDR_W-1:0] src2,
    input  logic [fir_pkg::ADDR_W-1:0] dest,
    input  logic [fir_pkg::EXT_W-1:0]  ext_data1,
    input  logic [fir_pkg::EXT_W-1:0]  ext_data2,
    output logic [REG_W-1:0]           outreg_data,
    output logic                       overflow
);
    import fir_pkg::*;

    localparam int unsigned PW = 2 * REG_W;

`ifdef FIR_DP_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef logic signed [REG_W-1:0] word_t;

    localparam word_t WORD_MAX = {1'b0, {(REG_W-1){1'b1}}};
    localparam word_t WORD_MIN = {1'b1, {(REG_W-1){1'b0}}};

    word_t              rd1;
    word_t              rd2;
    word_t              sum;
    word_t              diff;
    word_t              result;
    word_t              wdata;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic [PW-REG_W:0]  prod_hi;
    logic               we;
    logic               ovf;
    logic               ovf_pos;
    op_t                op_q;

    fir_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .we       (we),
        .waddr    (dest),
        .wdata    (wdata),
        .raddr1   (src1),
        .raddr2   (src2),
        .rdata1_c (rd1),
        .rdata2_c (rd2),
        .acc      (outreg_data)
    );

    // ALU, overflow detection and result select for the op presented this cycle.
    always_comb begin
        op_q    = op_t'(op);
        sum     = rd1 + rd2;
        diff    = rd1 - rd2;
        prod    = PW'(rd1) * PW'(rd2);
        prod_sh = prod >>> FRAC_W;
        prod_hi = prod_sh[PW-1:REG_W-1];
        result  = '0;
        ovf     = 1'b0;
        ovf_pos = 1'b0;

        case (op_q)
            OP_COPY:  result = rd1;
            OP_LOAD1: result = word_t'({{(REG_W-EXT_W){1'b0}}, ext_data1});
            OP_LOAD2: result = word_t'({{(REG_W-EXT_W){1'b0}}, ext_data2});
            OP_ADD: begin
                result  = sum;
                ovf     = (rd1[REG_W-1] == rd2[REG_W-1]) && (sum[REG_W-1] != rd1[REG_W-1]);
                ovf_pos = ~rd1[REG_W-1];
            end
            OP_SUB: begin
                result  = diff;
                ovf     = (rd1[REG_W-1] != rd2[REG_W-1]) && (diff[REG_W-1] != rd1[REG_W-1]);
                ovf_pos = ~rd1[REG_W-1];
            end
            OP_MUL: begin
                // Shifted product fits only if all bits above the result MSB copy the sign.
                result  = prod_sh[REG_W-1:0];
                ovf     = (prod_hi != '0) && (prod_hi != '1);
                ovf_pos = ~prod[PW-1];
            end
            default: ;
        endcase

        we    = op_writes(op_q);
        wdata = (SAT_EN && ovf) ? (ovf_pos ? WORD_MAX : WORD_MIN) : result;
    end

    assign overflow = ovf;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed self-checking bench for fir_datapath; expectations follow FIR_DP_SAT_EN when defined.
module tb_fir_datapath;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic [2:0]  op;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [15:0] ext_data1;
    logic [15:0] ext_data2;
    logic [16:0] outreg_data;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic        ovf_s;
    logic [16:0] v;

`ifdef FIR_DP_SAT_EN
    localparam logic [31:0] ADD_OVF_RES = 32'h0FFFF;
    localparam logic [31:0] MUL_OVF_RES = 32'h0FFFF;
    localparam logic [31:0] SUB_OVF_RES = 32'h10000;
`else
    localparam logic [31:0] ADD_OVF_RES = 32'h10000;
    localparam logic [31:0] MUL_OVF_RES = 32'h1FFFC;
    localparam logic [31:0] SUB_OVF_RES = 32'h0FFFF;
`endif

    always #5 clk = ~clk;

    fir_datapath dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .ext_data1   (ext_data1),
        .ext_data2   (ext_data2),
        .outreg_data (outreg_data),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input op_t o, input int s1, input int s2, input int d,
                         input int e1, input int e2);
        op        = o;
        src1      = 4'(s1);
        src2      = 4'(s2);
        dest      = 4'(d);
        ext_data1 = 16'(e1);
        ext_data2 = 16'(e2);
    endtask

    // Present one op, capture overflow mid-cycle, return 1 time unit after the committing edge.
    task automatic step(input op_t o, input int s1, input int s2, input int d,
                        input int e1, input int e2);
        drive(o, s1, s2, d, e1, e2);
        @(negedge clk);
        ovf_s = overflow;
        @(posedge clk);
        #1;
        op = OP_NOP;
    endtask

    task automatic read_reg(input int idx, output logic [16:0] val);
        step(OP_COPY, idx, 0, 0, 0, 0);
        val = outreg_data;
    endtask

    task automatic filter_pass(input int s1, input int s2, input int s3, input int s4,
                               output logic [16:0] acc, output logic ovf_any);
        int samp [4];
        int coef [4];
        samp = '{s1, s2, s3, s4};
        coef = '{32'h8000, 32'h4000, 32'h4000, 32'h8000};
        ovf_any = 1'b0;
        step(OP_SUB, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(OP_LOAD1, 0, 0, 1, samp[i], 0);
            step(OP_LOAD2, 0, 0, 2, 0, coef[i]);
            step(OP_MUL, 1, 2, 3, 0, 0);
            ovf_any |= ovf_s;
            step((i % 2 == 0) ? OP_ADD : OP_SUB, 0, 3, 0, 0, 0);
            ovf_any |= ovf_s;
        end
        acc = outreg_data;
    endtask

    initial begin
        logic fo;
        n_rst = 1'b0;
        clear = 1'b0;
        drive(OP_NOP, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reset_out", 32'(outreg_data), 32'h0);
        check("reset_ovf", 32'(overflow), 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        step(OP_LOAD1, 0, 0, 5, 16'h1234, 0);
        check("load1_ovf", 32'(ovf_s), 32'h0);
        step(OP_COPY, 5, 0, 1, 0, 0);
        check("copy_ovf", 32'(ovf_s), 32'h0);
        read_reg(1, v);
        check("copy_r1", 32'(v), 32'h01234);

        step(OP_LOAD2, 0, 0, 10, 0, 16'h8000);
        step(OP_LOAD1, 0, 0, 1, 100, 0);
        step(OP_MUL, 1, 10, 6, 0, 0);
        check("mul_unity_ovf", 32'(ovf_s), 32'h0);
        read_reg(6, v);
        check("mul_unity_r6", 32'(v), 32'd100);

        step(OP_LOAD1, 0, 0, 1, 16'hFFFF, 0);
        step(OP_LOAD1, 0, 0, 6, 1, 0);
        step(OP_ADD, 1, 6, 0, 0, 0);
        check("add_ovf", 32'(ovf_s), 32'h1);
        check("add_ovf_res", 32'(outreg_data), ADD_OVF_RES);

        step(OP_LOAD1, 0, 0, 0, 5000, 0);
        check("acc_5000", 32'(outreg_data), 32'd5000);
        step(OP_SUB, 0, 0, 0, 0, 0);
        check("zero_acc_ovf", 32'(ovf_s), 32'h0);
        check("zero_acc", 32'(outreg_data), 32'h0);

        step(OP_LOAD2, 0, 0, 2, 0, 16'hFFFF);
        step(OP_MUL, 1, 2, 0, 0, 0);
        check("mul_big_ovf", 32'(ovf_s), 32'h1);
        check("mul_big_res", 32'(outreg_data), MUL_OVF_RES);

        step(OP_LOAD1, 0, 0, 7, 1, 0);
        step(OP_LOAD1, 0, 0, 8, 0, 0);
        step(OP_SUB, 8, 7, 9, 0, 0);
        check("sub_neg_ovf", 32'(ovf_s), 32'h0);
        step(OP_MUL, 9, 10, 0, 0, 0);
        check("mul_neg_ovf", 32'(ovf_s), 32'h0);
        check("mul_neg_res", 32'(outreg_data), 32'h1FFFF);

        step(OP_LOAD1, 0, 0, 7, 16'hFFFF, 0);
        step(OP_LOAD1, 0, 0, 12, 2, 0);
        step(OP_SUB, 8, 7, 13, 0, 0);
        check("sub_min_ovf", 32'(ovf_s), 32'h0);
        step(OP_SUB, 13, 12, 0, 0, 0);
        check("sub_ovf", 32'(ovf_s), 32'h1);
        check("sub_ovf_res", 32'(outreg_data), SUB_OVF_RES);

        step(OP_LOAD1, 0, 0, 4, 300, 0);
        step(OP_ADD, 4, 4, 4, 0, 0);
        read_reg(4, v);
        check("self_add", 32'(v), 32'd600);

        filter_pass(1000, 300, 500, 200, v, fo);
        check("filter1_ovf", 32'(fo), 32'h0);
        check("filter1_acc", 32'(v), 32'h00384);
        filter_pass(100, 1000, 50, 300, v, fo);
        check("filter2_ovf", 32'(fo), 32'h0);
        check("filter2_acc", 32'(v), 32'h1FD5D);

        step(OP_LOAD1, 0, 0, 0, 77, 0);
        check("pre_clear_acc", 32'(outreg_data), 32'd77);
        clear = 1'b1;
        step(OP_LOAD1, 0, 0, 3, 16'h0055, 0);
        clear = 1'b0;
        check("clear_ovf", 32'(ovf_s), 32'h0);
        check("clear_acc", 32'(outreg_data), 32'h0);
        read_reg(3, v);
        check("clear_r3", 32'(v), 32'h0);
        read_reg(5, v);
        check("clear_r5", 32'(v), 32'h0);

        step(OP_LOAD1, 0, 0, 1, 16'hFFFF, 0);
        step(OP_LOAD1, 0, 0, 6, 1, 0);
        clear = 1'b1;
        step(OP_ADD, 1, 6, 0, 0, 0);
        clear = 1'b0;
        check("clear_add_ovf", 32'(ovf_s), 32'h1);
        check("clear_add_acc", 32'(outreg_data), 32'h0);

        step(OP_LOAD1, 0, 0, 0, 1234, 0);
        step(OP_LOAD1, 0, 0, 5, 16'h4321, 0);
        check("pre_rst_acc", 32'(outreg_data), 32'd1234);
        drive(OP_MUL, 0, 0, 0, 0, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_acc", 32'(outreg_data), 32'h0);
        @(posedge clk);
        #1;
        op    = OP_NOP;
        n_rst = 1'b1;
        check("post_rst_acc", 32'(outreg_data), 32'h0);
        read_reg(5, v);
        check("post_rst_r5", 32'(v), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
